mario_motion_ctrl: RTL

Per-frame motion sequencer for the player sprite. It samples the keyboard keycode and the collision flags on each frame tick, and runs a ground/rise/apex/fall state machine. From that it issues one signed (dx, dy) step command per frame to the position datapath over a valid/ready handshake. It sits between the USB keycode path and the sprite position register, and replaces the ad-hoc jump counter inside the position logic.

---
 rtl/mario_motion_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mario_motion_ctrl.sv
// Per-frame player motion sequencer: ground/rise/apex/fall FSM issuing one (dx, dy) step per frame.
// Optional late-jump grace window: define MARIO_COYOTE_JUMP_EN.
module mario_motion_ctrl #(
    parameter int STEP_W        = 6,
    parameter int RUN_SPEED     = 2,
    parameter int RISE_SPEED    = 2,
    parameter int JUMP_FRAMES   = 32,
    parameter int APEX_FRAMES   = 4,
    parameter int GRAVITY_MAX   = 4,
    parameter int COYOTE_FRAMES = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [7:0]        keycode,
    input  logic              on_floor,
    input  logic              hit_ceiling,
    input  logic              at_left,
    input  logic              at_right,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [STEP_W-1:0] step_dx,
    output logic [STEP_W-1:0] step_dy,
    output logic [1:0]        motion_state,
    output logic              facing_left,
    output logic [7:0]        overrun_cnt
);

    localparam logic [1:0] GROUND = 2'b00;
    localparam logic [1:0] RISE   = 2'b01;
    localparam logic [1:0] APEX   = 2'b10;
    localparam logic [1:0] FALL   = 2'b11;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;

    localparam logic [STEP_W-1:0] RUN_POS  = STEP_W'(RUN_SPEED);
    localparam logic [STEP_W-1:0] RUN_NEG  = STEP_W'(-RUN_SPEED);
    localparam logic [STEP_W-1:0] RISE_NEG = STEP_W'(-RISE_SPEED);
    localparam logic [STEP_W-1:0] ONE      = STEP_W'(1);
    localparam logic [STEP_W-1:0] GMAX     = STEP_W'(GRAVITY_MAX);
    localparam logic [5:0]        JUMP_LD  = 6'(JUMP_FRAMES);
    localparam logic [3:0]        APEX_LD  = 4'(APEX_FRAMES);

    logic [1:0]        state;
    logic [5:0]        jump_cnt;
    logic [3:0]        apex_cnt;
    logic [STEP_W-1:0] fall_speed;

    logic [1:0]        nxt_state;
    logic [5:0]        nxt_jump;
    logic [3:0]        nxt_apex;
    logic [STEP_W-1:0] nxt_fall;
    logic [STEP_W-1:0] nxt_dx;
    logic [STEP_W-1:0] nxt_dy;
    logic              nxt_face;
    logic              accept;
    logic              coyote_jump;

    assign accept       = frame_tick & ~step_valid;
    assign motion_state = state;

`ifdef MARIO_COYOTE_JUMP_EN
    logic [7:0] coyote_cnt;
    logic [7:0] nxt_coyote;

    assign coyote_jump = (coyote_cnt != 8'd0) && (keycode == KEY_JUMP);

    always_comb begin
        nxt_coyote = coyote_cnt;
        case (state)
            GROUND:  nxt_coyote = on_floor ? 8'd0 : 8'(COYOTE_FRAMES);
            FALL: begin
                if (on_floor || coyote_jump)
                    nxt_coyote = 8'd0;
                else if (coyote_cnt != 8'd0)
                    nxt_coyote = coyote_cnt - 8'd1;
            end
            default: nxt_coyote = coyote_cnt;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            coyote_cnt <= 8'd0;
        else if (accept)
            coyote_cnt <= nxt_coyote;
    end
`else
    logic unused_cfg;
    assign coyote_jump = 1'b0;
    assign unused_cfg  = |COYOTE_FRAMES;
`endif

    // Horizontal command is independent of the vertical state.
    always_comb begin
        nxt_dx   = '0;
        nxt_face = facing_left;
        if (keycode == KEY_LEFT && !at_left) begin
            nxt_dx   = RUN_NEG;
            nxt_face = 1'b1;
        end else if (keycode == KEY_RIGHT && !at_right) begin
            nxt_dx   = RUN_POS;
            nxt_face = 1'b0;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_jump  = jump_cnt;
        nxt_apex  = apex_cnt;
        nxt_fall  = fall_speed;
        nxt_dy    = '0;
        case (state)
            GROUND: begin
                if (!on_floor) begin
                    nxt_state = FALL;
                    nxt_fall  = ONE;
                    nxt_dy    = ONE;
                end else if (keycode == KEY_JUMP && !hit_ceiling) begin
                    nxt_state = RISE;
                    nxt_jump  = JUMP_LD;
                    nxt_dy    = RISE_NEG;
                end
            end
            RISE: begin
                if (jump_cnt == 6'd1 || hit_ceiling || keycode == KEY_DOWN) begin
                    if (APEX_FRAMES > 0) begin
                        nxt_state = APEX;
                        nxt_apex  = APEX_LD;
                    end else begin
                        nxt_state = FALL;
                        nxt_fall  = ONE;
                        nxt_dy    = ONE;
                    end
                end else begin
                    nxt_jump = jump_cnt - 6'd1;
                    nxt_dy   = RISE_NEG;
                end
            end
            APEX: begin
                if (apex_cnt == 4'd1) begin
                    nxt_state = FALL;
                    nxt_fall  = ONE;
                    nxt_dy    = ONE;
                end else begin
                    nxt_apex = apex_cnt - 4'd1;
                end
            end
            FALL: begin
                if (on_floor) begin
                    nxt_state = GROUND;
                end else if (coyote_jump) begin
                    nxt_state = RISE;
                    nxt_jump  = JUMP_LD;
                    nxt_dy    = RISE_NEG;
                end else begin
                    if (keycode == KEY_DOWN || fall_speed >= GMAX)
                        nxt_fall = GMAX;
                    else
                        nxt_fall = fall_speed + ONE;
                    nxt_dy = (keycode == KEY_DOWN || fall_speed >= GMAX) ? GMAX : fall_speed + ONE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= GROUND;
            jump_cnt    <= '0;
            apex_cnt    <= '0;
            fall_speed  <= '0;
            step_valid  <= 1'b0;
            step_dx     <= '0;
            step_dy     <= '0;
            facing_left <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (accept) begin
                state       <= nxt_state;
                jump_cnt    <= nxt_jump;
                apex_cnt    <= nxt_apex;
                fall_speed  <= nxt_fall;
                step_dx     <= nxt_dx;
                step_dy     <= nxt_dy;
                facing_left <= nxt_face;
                step_valid  <= 1'b1;
            end else if (step_valid && step_ready) begin
                step_valid <= 1'b0;
            end
            if (frame_tick && step_valid && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule
